id_hazard_tracker: RTL and testbench

- Producer side of the ID-stage forwarding path in the 5-stage MIPS pipeline.
- Keeps a shift pipeline of in-flight destination tags (ID/EX, EX/MEM, MEM/WB).
- Drives the EX_MEM/MEM_WB Rd and RegWrite tags that the ID forwarding mux consumes.
- Raises a stall for hazards that forwarding cannot resolve: load-use, and a branch compared in ID against a not-yet-available result.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_slot_reg.sv | 37 +++
 rtl/id_hazard_tracker.sv | 121 ++++++++++++
 tb/tb_id_hazard_tracker.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard tracker: pipeline slot record, bubble constant and
// the source/destination match helper.
package hazard_pkg;

   localparam int unsigned SLOT_RD_W = 5;
   localparam logic [SLOT_RD_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [SLOT_RD_W-1:0] rd;
      logic                 regwrite;
      logic                 memread;
   } slot_t;

   localparam slot_t BUBBLE = '{rd: REG_ZERO, regwrite: 1'b0, memread: 1'b0};

   // $0 is never a real producer, so it can never create a dependency.
   function automatic logic slot_match(input slot_t                s,
                                       input logic                 use_rs,
                                       input logic [SLOT_RD_W-1:0] rs,
                                       input logic                 use_rt,
                                       input logic [SLOT_RD_W-1:0] rt);
      return (s.rd != REG_ZERO) && ((use_rs && (rs == s.rd)) || (use_rt && (rt == s.rd)));
   endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// One in-flight destination-tag slot: holds on freeze, loads a bubble on request and
// strips write/load flags from entries that target $0.
module hazard_slot_reg
   import hazard_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  i_hold,
   input  logic  i_bubble,
   input  slot_t i_slot,
   output slot_t o_slot
);

   slot_t w_next;
   slot_t r_slot;

   always_comb begin
      w_next = i_slot;
      if (i_bubble) begin
         w_next = BUBBLE;
      end else if (i_slot.rd == REG_ZERO) begin
         w_next.regwrite = 1'b0;
         w_next.memread  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot <= BUBBLE;
      end else if (!i_hold) begin
         r_slot <= w_next;
      end
   end

   assign o_slot = r_slot;

endmodule

// File: rtl/id_hazard_tracker.sv
// Tracks destination tags through ID/EX, EX/MEM, MEM/WB and raises the ID stall for
// load-use and unresolved branch-compare hazards. HAZARD_STATS_EN adds stall counters.
module id_hazard_tracker
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5
`ifdef HAZARD_STATS_EN
   ,
   parameter int unsigned STAT_W = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_is_branch,
   output logic              stall,
   output logic [REG_AW-1:0] id_ex_rd,
   output logic [REG_AW-1:0] ex_mem_rd,
   output logic [REG_AW-1:0] mem_wb_rd,
   output logic              id_ex_regwrite,
   output logic              ex_mem_regwrite,
   output logic              mem_wb_regwrite,
   output logic              ex_mem_memread
`ifdef HAZARD_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_loaduse_cnt,
   output logic [STAT_W-1:0] stat_branch_cnt
`endif
);

   slot_t w_id_entry;
   slot_t w_id_ex;
   slot_t w_ex_mem;
   slot_t w_mem_wb;
   logic  w_match_ex;
   logic  w_match_mem;
   logic  w_load_use;
   logic  w_br_ex;
   logic  w_br_mem;
   logic  w_id_ex_bubble;

   assign w_id_entry = '{rd: id_rd, regwrite: id_regwrite, memread: id_memread};

   assign w_match_ex  = slot_match(w_id_ex, id_use_rs, id_rs, id_use_rt, id_rt);
   assign w_match_mem = slot_match(w_ex_mem, id_use_rs, id_rs, id_use_rt, id_rt);

   assign w_load_use = w_id_ex.memread & w_match_ex;
   assign w_br_ex    = id_is_branch & w_id_ex.regwrite & w_match_ex;
   // An ALU result in EX/MEM forwards to ID; only a load there is still too late.
   assign w_br_mem   = id_is_branch & w_ex_mem.memread & w_match_mem;

   assign stall          = id_valid & ~flush & (w_load_use | w_br_ex | w_br_mem);
   assign w_id_ex_bubble = flush | stall | ~id_valid;

   hazard_slot_reg u_slot_id_ex (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hold   (freeze),
      .i_bubble (w_id_ex_bubble),
      .i_slot   (w_id_entry),
      .o_slot   (w_id_ex)
   );

   hazard_slot_reg u_slot_ex_mem (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hold   (freeze),
      .i_bubble (1'b0),
      .i_slot   (w_id_ex),
      .o_slot   (w_ex_mem)
   );

   hazard_slot_reg u_slot_mem_wb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hold   (freeze),
      .i_bubble (1'b0),
      .i_slot   (w_ex_mem),
      .o_slot   (w_mem_wb)
   );

   assign id_ex_rd        = w_id_ex.rd;
   assign id_ex_regwrite  = w_id_ex.regwrite;
   assign ex_mem_rd       = w_ex_mem.rd;
   assign ex_mem_regwrite = w_ex_mem.regwrite;
   assign ex_mem_memread  = w_ex_mem.memread;
   assign mem_wb_rd       = w_mem_wb.rd;
   assign mem_wb_regwrite = w_mem_wb.regwrite;

`ifdef HAZARD_STATS_EN
   logic [STAT_W-1:0] r_loaduse_cnt;
   logic [STAT_W-1:0] r_branch_cnt;

   // Load-use takes precedence when a stall has several causes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_loaduse_cnt <= '0;
         r_branch_cnt  <= '0;
      end else if (!freeze && stall) begin
         if (w_load_use) begin
            if (r_loaduse_cnt != '1) r_loaduse_cnt <= r_loaduse_cnt + 1'b1;
         end else begin
            if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
         end
      end
   end

   assign stat_loaduse_cnt = r_loaduse_cnt;
   assign stat_branch_cnt  = r_branch_cnt;
`endif

endmodule

// File: tb/tb_id_hazard_tracker.sv
// Scoreboard bench for id_hazard_tracker; covers the HAZARD_STATS_EN counters when defined.
module tb_id_hazard_tracker;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
      logic [4:0] rs;
      logic       use_rs;
      logic [4:0] rt;
      logic       use_rt;
      logic       br;
   } ins_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } mslot_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       freeze = 1'b0;
   logic       flush = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rd = '0;
   logic       id_regwrite = 1'b0;
   logic       id_memread = 1'b0;
   logic [4:0] id_rs = '0;
   logic [4:0] id_rt = '0;
   logic       id_use_rs = 1'b0;
   logic       id_use_rt = 1'b0;
   logic       id_is_branch = 1'b0;
   logic       stall;
   logic [4:0] id_ex_rd, ex_mem_rd, mem_wb_rd;
   logic       id_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite, ex_mem_memread;
`ifdef HAZARD_STATS_EN
   logic [31:0] stat_loaduse_cnt, stat_branch_cnt;
   int unsigned m_lu_cnt, m_br_cnt;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   mslot_t m_idex, m_exmem, m_memwb;
   logic         q_stall[$];
   logic [18:0]  q_tags[$];

   always #5 clk = ~clk;

   id_hazard_tracker #(.REG_AW(5)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .freeze          (freeze),
      .flush           (flush),
      .id_valid        (id_valid),
      .id_rd           (id_rd),
      .id_regwrite     (id_regwrite),
      .id_memread      (id_memread),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_use_rs       (id_use_rs),
      .id_use_rt       (id_use_rt),
      .id_is_branch    (id_is_branch),
      .stall           (stall),
      .id_ex_rd        (id_ex_rd),
      .ex_mem_rd       (ex_mem_rd),
      .mem_wb_rd       (mem_wb_rd),
      .id_ex_regwrite  (id_ex_regwrite),
      .ex_mem_regwrite (ex_mem_regwrite),
      .mem_wb_regwrite (mem_wb_regwrite),
      .ex_mem_memread  (ex_mem_memread)
`ifdef HAZARD_STATS_EN
      ,
      .stat_loaduse_cnt (stat_loaduse_cnt),
      .stat_branch_cnt  (stat_branch_cnt)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic ins_t f_nop();
      return '0;
   endfunction

   function automatic ins_t f_lw(input logic [4:0] rd);
      ins_t i = '0;
      i.valid = 1'b1; i.rd = rd; i.rw = 1'b1; i.mr = 1'b1;
      return i;
   endfunction

   function automatic ins_t f_alu(input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                                  input logic [4:0] rt, input logic urt);
      ins_t i = '0;
      i.valid = 1'b1; i.rd = rd; i.rw = 1'b1;
      i.rs = rs; i.use_rs = urs; i.rt = rt; i.use_rt = urt;
      return i;
   endfunction

   function automatic ins_t f_br(input logic [4:0] rs, input logic [4:0] rt);
      ins_t i = '0;
      i.valid = 1'b1; i.rs = rs; i.use_rs = 1'b1; i.rt = rt; i.use_rt = 1'b1; i.br = 1'b1;
      return i;
   endfunction

   function automatic logic hit(input mslot_t s, input ins_t i);
      return (s.rd != 5'd0) && ((i.use_rs && i.rs == s.rd) || (i.use_rt && i.rt == s.rd));
   endfunction

   function automatic logic [18:0] pack_model();
      return {m_idex.rd, m_idex.rw, m_exmem.rd, m_exmem.rw, m_exmem.mr, m_memwb.rd, m_memwb.rw};
   endfunction

   function automatic logic [18:0] pack_dut();
      return {id_ex_rd, id_ex_regwrite, ex_mem_rd, ex_mem_regwrite, ex_mem_memread,
              mem_wb_rd, mem_wb_regwrite};
   endfunction

   task automatic model_reset();
      m_idex = '0; m_exmem = '0; m_memwb = '0;
`ifdef HAZARD_STATS_EN
      m_lu_cnt = 0; m_br_cnt = 0;
`endif
   endtask

   task automatic set_in(input ins_t i, input logic fl, input logic frz);
      id_valid = i.valid; id_rd = i.rd; id_regwrite = i.rw; id_memread = i.mr;
      id_rs = i.rs; id_use_rs = i.use_rs; id_rt = i.rt; id_use_rt = i.use_rt;
      id_is_branch = i.br; flush = fl; freeze = frz;
   endtask

   // One cycle: drive, predict, check stall before the edge and tags after it.
   task automatic cyc(input ins_t i, input logic fl, input logic frz, output logic st);
      logic   lu, m_st;
      mslot_t ent;
      @(negedge clk);
      set_in(i, fl, frz);
      lu   = m_idex.mr && hit(m_idex, i);
      m_st = i.valid && !fl && (lu || (i.br && m_idex.rw && hit(m_idex, i)) ||
                                (i.br && m_exmem.mr && hit(m_exmem, i)));
      q_stall.push_back(m_st);
      if (!frz) begin
         ent = '{rd: i.rd, rw: i.rw && i.rd != 5'd0, mr: i.mr && i.rd != 5'd0};
         m_memwb = m_exmem;
         m_exmem = m_idex;
         m_idex  = (fl || m_st || !i.valid) ? mslot_t'(0) : ent;
`ifdef HAZARD_STATS_EN
         if (m_st) begin
            if (lu) m_lu_cnt++;
            else m_br_cnt++;
         end
`endif
      end
      q_tags.push_back(pack_model());
      #1;
      check_val("stall", 32'(stall), 32'(q_stall.pop_front()));
      @(posedge clk);
      #1;
      check_val("tags", 32'(pack_dut()), 32'(q_tags.pop_front()));
`ifdef HAZARD_STATS_EN
      check_val("stat_lu", stat_loaduse_cnt, m_lu_cnt);
      check_val("stat_br", stat_branch_cnt, m_br_cnt);
`endif
      st = m_st;
   endtask

   task automatic drain();
      logic st;
      for (int k = 0; k < 3; k++) cyc(f_nop(), 1'b0, 1'b0, st);
   endtask

   initial begin
      logic st;
      model_reset();
      #12;
      check_val("rst_stall", 32'(stall), 32'd0);
      check_val("rst_tags", 32'(pack_dut()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drain();

      // Load feeding an ALU op: one stall, lw reaches EX/MEM two edges later.
      cyc(f_lw(5'd8), 1'b0, 1'b0, st);
      check_val("lw_alu_first", 32'(st), 32'd0);
      cyc(f_alu(5'd1, 5'd8, 1'b1, 5'd2, 1'b1), 1'b0, 1'b0, st);
      check_val("lw_alu_stall1", 32'(stall), 32'd0);
      check_val("lw_alu_exmem_rd", 32'(ex_mem_rd), 32'd8);
      check_val("lw_alu_exmem_mr", 32'(ex_mem_memread), 32'd1);
      check_val("lw_alu_bubble", 32'(id_ex_rd), 32'd0);
      cyc(f_alu(5'd1, 5'd8, 1'b1, 5'd2, 1'b1), 1'b0, 1'b0, st);
      check_val("lw_alu_release", 32'(st), 32'd0);
      drain();

      // Load feeding a branch: two stall cycles.
      cyc(f_lw(5'd9), 1'b0, 1'b0, st);
      cyc(f_br(5'd4, 5'd9), 1'b0, 1'b0, st);
      check_val("lw_br_st1", 32'(st), 32'd1);
      cyc(f_br(5'd4, 5'd9), 1'b0, 1'b0, st);
      check_val("lw_br_st2", 32'(st), 32'd1);
      check_val("lw_br_memwb_rd", 32'(mem_wb_rd), 32'd9);
      cyc(f_br(5'd4, 5'd9), 1'b0, 1'b0, st);
      check_val("lw_br_release", 32'(st), 32'd0);
      drain();

      // ALU result feeding a branch: one stall.
      cyc(f_alu(5'd3, 5'd1, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0, st);
      cyc(f_br(5'd3, 5'd7), 1'b0, 1'b0, st);
      check_val("alu_br_st", 32'(st), 32'd1);
      check_val("alu_br_exmem_rd", 32'(ex_mem_rd), 32'd3);
      check_val("alu_br_exmem_rw", 32'(ex_mem_regwrite), 32'd1);
      cyc(f_br(5'd3, 5'd7), 1'b0, 1'b0, st);
      check_val("alu_br_release", 32'(st), 32'd0);
      drain();

      // $0 destination and unused sources never stall.
      cyc(f_lw(5'd0), 1'b0, 1'b0, st);
      check_val("lw0_idex_rw", 32'(id_ex_regwrite), 32'd0);
      cyc(f_alu(5'd2, 5'd0, 1'b1, 5'd0, 1'b1), 1'b0, 1'b0, st);
      check_val("lw0_nostall", 32'(st), 32'd0);
      check_val("lw0_exmem", 32'({ex_mem_regwrite, ex_mem_memread}), 32'd0);
      cyc(f_lw(5'd5), 1'b0, 1'b0, st);
      cyc(f_alu(5'd2, 5'd1, 1'b1, 5'd5, 1'b0), 1'b0, 1'b0, st);
      check_val("unused_rt_nostall", 32'(st), 32'd0);
      drain();

      // Freeze holds all three slots.
      cyc(f_alu(5'd4, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 1'b0, st);
      cyc(f_alu(5'd5, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 1'b0, st);
      cyc(f_alu(5'd6, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 1'b0, st);
      for (int k = 0; k < 3; k++) cyc(f_alu(5'd7, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 1'b1, st);
      check_val("frz_rds", 32'({id_ex_rd, ex_mem_rd, mem_wb_rd}), 32'({5'd6, 5'd5, 5'd4}));
      drain();

      // Flush beats a load-use match.
      cyc(f_lw(5'd10), 1'b0, 1'b0, st);
      cyc(f_alu(5'd2, 5'd10, 1'b1, 5'd0, 1'b0), 1'b1, 1'b0, st);
      check_val("flush_nostall", 32'(st), 32'd0);
      check_val("flush_bubble", 32'(id_ex_rd), 32'd0);
      drain();

`ifdef HAZARD_STATS_EN
      check_val("stat_lu_total", stat_loaduse_cnt, 32'd2);
      check_val("stat_br_total", stat_branch_cnt, 32'd2);
`endif

      // Asynchronous reset while a stall is active.
      cyc(f_lw(5'd11), 1'b0, 1'b0, st);
      cyc(f_lw(5'd12), 1'b0, 1'b0, st);
      @(negedge clk);
      set_in(f_alu(5'd2, 5'd12, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0);
      #1;
      check_val("pre_rst_stall", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_stall", 32'(stall), 32'd0);
      check_val("mid_rst_tags", 32'(pack_dut()), 32'd0);
      model_reset();
      @(negedge clk);
      set_in(f_nop(), 1'b0, 1'b0);
      rst_n = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
